// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus: tag/value widths, the invalid tag
// encoding (mirrors common_def.h) and the {tag, val} entry that flows through the CDB.
package cdb_arbiter_pkg;

  localparam int INST_TAG_WIDTH = 6;
  localparam int COMMON_WIDTH   = 32;

  localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic [INST_TAG_WIDTH-1:0] tag;
    logic [COMMON_WIDTH-1:0]   val;
  } cdb_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Per-requester result buffer: a small circular FIFO with a registered occupancy
// count. push_i/pop_i arrive already qualified (ready / non-empty / no flush).
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  cdb_entry_t       din_i,
  output cdb_entry_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ready_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  cdb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
  assign ready_o = (count_q < DEPTH_C);

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers functional-unit results per requester and
// broadcasts one per cycle onto registered cdb_* outputs, round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int FIFO_DEPTH = 2,
  localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*INST_TAG_WIDTH-1:0] req_tag,
  input  logic [NUM_REQ*COMMON_WIDTH-1:0]   req_val,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              cdb_valid,
  output logic [INST_TAG_WIDTH-1:0]         cdb_tag,
  output logic [COMMON_WIDTH-1:0]           cdb_val,
  output logic [SRC_W-1:0]                  cdb_src
);

  // Handshake: a requester's result is taken at a rising edge when req_valid[i]
  // and req_ready[i] are both high; while not ready it must hold tag/val stable.

  localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_REQ - 1);

  cdb_entry_t         entry_in [NUM_REQ];
  cdb_entry_t         head     [NUM_REQ];
  logic [CNT_W-1:0]   count    [NUM_REQ];
  logic [NUM_REQ-1:0] push, pop, nonempty;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand_idx;
  int                 cand;

  logic                      cdb_valid_q, cdb_valid_d;
  logic [INST_TAG_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
  logic [COMMON_WIDTH-1:0]   cdb_val_q, cdb_val_d;
  logic [SRC_W-1:0]          cdb_src_q, cdb_src_d;
  logic [SRC_W-1:0]          last_grant_q, last_grant_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    assign entry_in[g] = {req_tag[g*INST_TAG_WIDTH +: INST_TAG_WIDTH],
                          req_val[g*COMMON_WIDTH +: COMMON_WIDTH]};
    // Invalid-tag results complete the handshake but are dropped here.
    assign push[g] = req_valid[g] && req_ready[g] && !flush
                     && (req_tag[g*INST_TAG_WIDTH +: INST_TAG_WIDTH] != TAG_INVALID);
    assign pop[g]      = grant_found && (grant_idx == SRC_W'(g)) && !flush;
    assign nonempty[g] = (count[g] != '0);

    result_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .din_i   (entry_in[g]),
      .head_o  (head[g]),
      .count_o (count[g]),
      .ready_o (req_ready[g])
    );
  end

  // Round-robin: first non-empty FIFO starting just after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = SRC_W'(cand);
      if (!grant_found && nonempty[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    cdb_valid_d  = 1'b0;
    cdb_tag_d    = TAG_INVALID;
    cdb_val_d    = '0;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      last_grant_d = LAST_INIT;
    end else if (grant_found) begin
      cdb_valid_d  = 1'b1;
      cdb_tag_d    = head[grant_idx].tag;
      cdb_val_d    = head[grant_idx].val;
      cdb_src_d    = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= TAG_INVALID;
      cdb_val_q    <= '0;
      cdb_src_q    <= '0;
      last_grant_q <= LAST_INIT;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_val_q    <= cdb_val_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_val   = cdb_val_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts into a queue,
// a negedge monitor pops and compares every cycle the CDB is valid.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int TW    = INST_TAG_WIDTH;
  localparam int VW    = COMMON_WIDTH;
  localparam int SW    = 2;
  localparam int EXP_W = SW + TW + VW;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*VW-1:0] req_val;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [VW-1:0]   cdb_val;
  logic [SW-1:0]   cdb_src;

  cdb_arbiter #(
    .NUM_REQ    (N),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_val   (req_val),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_val   (cdb_val),
    .cdb_src   (cdb_src)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cdb_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_bcast: got src=%0d tag=%0h val=%0h, expected no broadcast (t=%0t)",
                 cdb_src, cdb_tag, cdb_val, $time);
      end else begin
        check("cdb_order", 64'({cdb_src, cdb_tag, cdb_val}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] val_of(input logic [TW-1:0] t);
    return 32'hC0DE_0000 | {{(VW-TW){1'b0}}, t};
  endfunction

  task automatic set_req(input int i, input logic v, input logic [TW-1:0] t);
    req_valid[i]         = v;
    req_tag[i*TW +: TW]  = t;
    req_val[i*VW +: VW]  = val_of(t);
  endtask

  task automatic expect_bcast(input logic [SW-1:0] s, input logic [TW-1:0] t, input logic [VW-1:0] v);
    exp_q.push_back({s, t, v});
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // stimulus
  initial begin
    int idx0, idx1, cyc, accept3;
    logic [N-1:0] rdy;

    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_val   = '0;
    #1 rst = 1'b1;
    #10;
    check("rst_ready", 64'(req_ready), 64'hF);
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_tag",   64'(cdb_tag),   64'(TAG_INVALID));
    check("rst_val",   64'(cdb_val),   64'd0);
    check("rst_src",   64'(cdb_src),   64'd0);
    #1 rst = 1'b0;

    // single push: req0 tag 5 at edge 1, broadcast after edge 2, idle after edge 3
    req_valid[0]      = 1'b1;
    req_tag[0 +: TW]  = 6'd5;
    req_val[0 +: VW]  = 32'h1234;
    expect_bcast(2'd0, 6'd5, 32'h1234);
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_tag",   64'(cdb_tag),   64'd5);
    check("single_val",   64'(cdb_val),   64'h1234);
    check("single_src",   64'(cdb_src),   64'd0);
    tick();
    check("single_idle_valid", 64'(cdb_valid), 64'd0);
    check("single_idle_tag",   64'(cdb_tag),   64'(TAG_INVALID));
    drain(5);

    // round-robin: flush to restore last_grant=3, then one entry in every FIFO
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, TW'(10 + i));
      expect_bcast(SW'(i), TW'(10 + i), val_of(TW'(10 + i)));
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      check("rr_valid", 64'(cdb_valid), 64'd1);
      check("rr_src",   64'(cdb_src),   64'(k));
    end
    drain(5);

    // backpressure: req1 streams tags 1,2,3 while req0 keeps its FIFO occupied
    expect_bcast(2'd0, 6'd20, val_of(6'd20));
    expect_bcast(2'd1, 6'd1,  val_of(6'd1));
    expect_bcast(2'd0, 6'd21, val_of(6'd21));
    expect_bcast(2'd1, 6'd2,  val_of(6'd2));
    expect_bcast(2'd0, 6'd22, val_of(6'd22));
    expect_bcast(2'd1, 6'd3,  val_of(6'd3));
    expect_bcast(2'd0, 6'd23, val_of(6'd23));
    idx0 = 0;
    idx1 = 0;
    cyc = 0;
    accept3 = -1;
    while ((idx0 < 4 || idx1 < 3) && cyc < 20) begin
      set_req(0, idx0 < 4, TW'(20 + idx0));
      set_req(1, idx1 < 3, TW'(1 + idx1));
      rdy = req_ready;
      tick();
      cyc++;
      if (req_valid[0] && rdy[0]) idx0++;
      if (req_valid[1] && rdy[1]) begin
        if (idx1 == 2) accept3 = cyc;
        idx1++;
      end
      if (cyc == 2) check("bp_ready1_low", 64'(req_ready[1]), 64'd0);
      if (cyc == 3) check("bp_ready1_back", 64'(req_ready[1]), 64'd1);
    end
    req_valid = '0;
    check("bp_tag3_accept_cycle", 64'(accept3), 64'd4);
    drain(10);

    // flush: three buffered entries plus a same-edge push, none may ever broadcast
    set_req(0, 1'b1, 6'd30);
    set_req(1, 1'b1, 6'd31);
    set_req(2, 1'b1, 6'd32);
    tick();
    req_valid = '0;
    set_req(3, 1'b1, 6'd33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = '0;
    check("flush_valid", 64'(cdb_valid), 64'd0);
    check("flush_tag",   64'(cdb_tag),   64'(TAG_INVALID));
    check("flush_ready", 64'(req_ready), 64'hF);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("flush_idle", 64'(cdb_valid), 64'd0);
    end

    // invalid tag: two accepted handshakes, nothing stored or broadcast
    set_req(2, 1'b1, TAG_INVALID);
    check("inv_ready_before", 64'(req_ready[2]), 64'd1);
    tick();
    check("inv_ready_mid", 64'(req_ready[2]), 64'd1);
    tick();
    req_valid = '0;
    check("inv_ready_after", 64'(req_ready), 64'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("inv_idle", 64'(cdb_valid), 64'd0);
    end

    // async reset mid-cycle with entries buffered
    set_req(0, 1'b1, 6'd40);
    set_req(1, 1'b1, 6'd41);
    set_req(3, 1'b1, 6'd43);
    tick();
    req_valid = '0;
    tick();
    check("ar_pre_valid", 64'(cdb_valid), 64'd1);
    check("ar_pre_tag",   64'(cdb_tag),   64'd40);
    #2 rst = 1'b1;
    #1;
    check("ar_valid_async", 64'(cdb_valid), 64'd0);
    check("ar_tag_async",   64'(cdb_tag),   64'(TAG_INVALID));
    check("ar_val_async",   64'(cdb_val),   64'd0);
    check("ar_ready_async", 64'(req_ready), 64'hF);
    #2 rst = 1'b0;
    tick();
    check("ar_first_edge", 64'(cdb_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ar_idle", 64'(cdb_valid), 64'd0);
    end
    check("ar_ready_end", 64'(req_ready), 64'hF);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of functional-unit requesters (ALU, LSU, branch, mul).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning result-buffer entries per requester (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit, reset: asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1 bit, synchronous pipeline flush (mispredict).
REQ-006 SHALL have port req_valid, input, NUM_REQ bits, per-requester result valid.
REQ-007 SHALL have port req_tag, input, NUM_REQ x INST_TAG_WIDTH, per-requester destination ROB tag.
REQ-008 SHALL have port req_val, input, NUM_REQ x COMMON_WIDTH, per-requester result value.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits, per-requester buffer can accept.
REQ-010 SHALL have port cdb_valid, output, 1 bit, broadcast valid this cycle.
REQ-011 SHALL have port cdb_tag, output, INST_TAG_WIDTH, broadcast ROB tag.
REQ-012 SHALL have port cdb_val, output, COMMON_WIDTH, broadcast value.
REQ-013 SHALL have port cdb_src, output, clog2(NUM_REQ), index of the granted requester.

Function
REQ-014 SHALL keep one FIFO per requester, depth FIFO_DEPTH, with a registered occupancy count.
REQ-015 SHALL drive req_ready[i] = (count[i] < FIFO_DEPTH), decoded from registers only; a same-cycle pop SHALL give no credit.
REQ-016 SHALL push {tag, val} on a rising edge when req_valid[i] && req_ready[i]; req_valid while not ready SHALL be ignored and the requester holds its data.
REQ-017 SHALL discard an accepted request whose tag equals TAG_INVALID (handshake completes, nothing stored).
REQ-018 SHALL arbitrate each cycle among FIFOs non-empty at the start of the cycle, round-robin: search starts at (last_grant+1) mod NUM_REQ.
REQ-019 SHALL, on grant, pop the head and register it onto cdb_* at the same edge; cdb outputs SHALL be registered.
REQ-020 SHALL give a minimum latency of one cycle: an entry pushed at edge N appears on the CDB after edge N+1.
REQ-021 SHALL, with no eligible FIFO, drive cdb_valid=0, cdb_tag=TAG_INVALID, cdb_val=0, and hold cdb_src and last_grant.
REQ-022 SHALL grant at most one entry per cycle and never skip a non-empty requester for more than NUM_REQ-1 grants.
REQ-023 SHALL allow push and pop of the same FIFO at the same edge when 0 < count < FIFO_DEPTH; count is unchanged.
REQ-024 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-025 SHALL, on flush at an edge, empty all FIFOs, ignore same-edge pushes, force cdb_valid=0 and cdb_tag=TAG_INVALID, and set last_grant=NUM_REQ-1.

Reset
REQ-026 SHALL, while rst is high, asynchronously force all counts and pointers to 0, req_ready to all ones (after decode), cdb_valid=0, cdb_tag=TAG_INVALID, cdb_val=0, cdb_src=0, and last_grant=NUM_REQ-1.
REQ-027 SHALL discard all buffered results on reset mid-operation, with no broadcast on the first edge after deassertion.

Structure
REQ-028 SHALL take INST_TAG_WIDTH, COMMON_WIDTH, and TAG_INVALID from the shared common_def.h; a cdb_entry typedef {tag, val} SHALL go in the shared package.
REQ-029 SHALL instantiate sub-module result_fifo (depth-parameterised, count/ready/head outputs) once per requester.

Verification
REQ-030 SHALL verify single push: req0 {tag=5, val=0x1234} at edge 1 -> cdb_valid=1, tag=5, val=0x1234, src=0 after edge 2; idle after edge 3.
REQ-031 SHALL verify round-robin: all 4 FIFOs hold one entry, last_grant=3 -> cdb_src sequence 0,1,2,3 on consecutive cycles.
REQ-032 SHALL verify backpressure: req1 pushes tags 1,2,3 in back-to-back cycles while req0 continuously holds entries -> req_ready[1]=0 after 2 pushes; tag 3 accepted only after a grant to 1; order 1,2,3 preserved.
REQ-033 SHALL verify flush: 3 entries buffered, flush for 1 cycle -> cdb_valid=0 next cycle, all req_ready=1, and no buffered tag ever broadcast.
REQ-034 SHALL verify invalid tag: req2 pushes tag=TAG_INVALID -> handshake completes, no CDB broadcast.
REQ-035 SHALL verify async reset: assert rst mid-cycle with entries buffered -> cdb_valid falls immediately without a clock edge, and all FIFOs are empty after deassertion.
